inbuf_offset_cal: RTL

- Multi-channel input-buffer offset calibration sequencer; the next generation of the single-buffer OSC/OSC_EN offset trim.
- Sweeps the 4-bit sign-magnitude offset code on NUM_CH input buffers in parallel, samples each buffer output, and locks the first code giving a majority of ones.
- Sits between the PHY input buffers and the DDR training controller, which issues start and reads cal_code/cal_err.

---
 rtl/inbuf_cal_pkg.sv | 25 ++
 rtl/inbuf_cal_chan.sv | 71 +++++++
 rtl/inbuf_offset_cal.sv | 116 +++++++++++
 3 files changed

// File: rtl/inbuf_cal_pkg.sv
// rtl/inbuf_cal_pkg.sv - shared FSM states, constants and sweep-index to offset-code mapping
package inbuf_cal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_DONE
   } cal_state_t;

   localparam logic [3:0] CODE_ZERO    = 4'b1000;
   localparam logic [3:0] CODE_MAX_NEG = 4'b0111;
   localparam logic [3:0] K_LAST       = 4'd14;

   // Index 7 is the zero point; below it the magnitude counts down on the negative side.
   function automatic logic [3:0] idx_to_code(input logic [3:0] k);
      if (k < 4'd7)
         return {1'b0, 3'(4'd7 - k)};
      else
         return {1'b1, 3'(k - 4'd7)};
   endfunction

endpackage

// File: rtl/inbuf_cal_chan.sv
// rtl/inbuf_cal_chan.sv - one input buffer: synchroniser, ones counter, lock/err state, osc mux
module inbuf_cal_chan
   import inbuf_cal_pkg::*;
#(
   parameter int SAMPLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       buf_raw,
   input  logic       clr,
   input  logic       setup,
   input  logic       sample_en,
   input  logic       eval_en,
   input  logic       done_en,
   input  logic       active,
   input  logic [3:0] code,
   output logic [3:0] osc,
   output logic [3:0] cal_code,
   output logic       cal_err,
   output logic       locked,
   output logic       lock_now
);

   localparam int CW = $clog2(SAMPLES + 1);
   localparam logic [CW-1:0] HALF = CW'(SAMPLES / 2);

   logic [1:0]    sync;
   logic [CW-1:0] ones;
   logic [3:0]    cur_code;

   // Exactly half ones is not a majority, so a toggling buffer never locks.
   assign lock_now = eval_en && !locked && (ones > HALF);
   assign osc      = (active && !locked) ? cur_code : cal_code;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync     <= 2'b00;
         ones     <= '0;
         cur_code <= CODE_ZERO;
      end else begin
         sync <= {sync[0], buf_raw};
         if (setup) begin
            ones <= '0;
            if (!locked)
               cur_code <= code;
         end else if (sample_en && !locked) begin
            ones <= ones + CW'(sync[1]);
         end
      end
   end

   // Locking on the most negative code means the buffer was already saturated high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked   <= 1'b0;
         cal_err  <= 1'b0;
         cal_code <= CODE_ZERO;
      end else if (clr) begin
         locked  <= 1'b0;
         cal_err <= 1'b0;
      end else if (lock_now) begin
         locked   <= 1'b1;
         cal_code <= cur_code;
         cal_err  <= (cur_code == CODE_MAX_NEG);
      end else if (done_en && !locked) begin
         cal_err  <= 1'b1;
         cal_code <= CODE_ZERO;
      end
   end

endmodule

// File: rtl/inbuf_offset_cal.sv
// rtl/inbuf_offset_cal.sv - multi-channel input-buffer offset calibration sequencer
module inbuf_offset_cal
   import inbuf_cal_pkg::*;
#(
   parameter int NUM_CH        = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int SAMPLES       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [NUM_CH-1:0]     buf_o,
   output logic [4*NUM_CH-1:0]   osc,
   output logic [NUM_CH-1:0]     osc_en,
   output logic [4*NUM_CH-1:0]   cal_code,
   output logic [NUM_CH-1:0]     cal_err,
   output logic                  code_valid
);

   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   cal_state_t        state;
   logic [3:0]        k;
   logic [CNT_W-1:0]  cnt;
   logic [NUM_CH-1:0] locked;
   logic [NUM_CH-1:0] lock_now;
   logic              all_locked_next;

   // Channels locking on this EVAL edge must count toward the early exit.
   assign all_locked_next = &(locked | lock_now);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      inbuf_cal_chan #(.SAMPLES(SAMPLES)) u_chan (
         .clk       (clk),
         .rst       (rst),
         .buf_raw   (buf_o[c]),
         .clr       ((state == ST_IDLE) && start),
         .setup     (state == ST_SETUP),
         .sample_en (state == ST_SAMPLE),
         .eval_en   (state == ST_EVAL),
         .done_en   (state == ST_DONE),
         .active    (state != ST_IDLE),
         .code      (idx_to_code(k)),
         .osc       (osc[4*c +: 4]),
         .cal_code  (cal_code[4*c +: 4]),
         .cal_err   (cal_err[c]),
         .locked    (locked[c]),
         .lock_now  (lock_now[c])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         k          <= 4'd0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         osc_en     <= '0;
         code_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_SETUP;
                  k          <= 4'd0;
                  busy       <= 1'b1;
                  code_valid <= 1'b0;
               end
            end
            ST_SETUP: begin
               osc_en <= '1;
               cnt    <= '0;
               state  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= ST_SAMPLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (cnt == CNT_W'(SAMPLES - 1)) begin
                  cnt   <= '0;
                  state <= ST_EVAL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_EVAL: begin
               if (all_locked_next || (k == K_LAST)) begin
                  state <= ST_DONE;
               end else begin
                  k     <= k + 4'd1;
                  state <= ST_SETUP;
               end
            end
            ST_DONE: begin
               done       <= 1'b1;
               code_valid <= 1'b1;
               osc_en     <= '0;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
